mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage controller; the consumer end of the EX/MEM pipeline register.
- Takes the latched EX/MEM fields: memRead, memWrite, word, regWrite, rd, result (address) and readData2 (store data).
- Runs a req/ack handshake to the data memory, stalls the pipeline while an access is outstanding, and presents registered writeback fields to MEM/WB.
- Handles word and byte (lb/sb) accesses, little-endian lane selection and a wait-timeout guard.

Parameters:
- MAX_WAIT, 255, max BUSY cycles without mem_ack before abort (1..255).
- CNT_W, 8, width of the wait counter; must hold MAX_WAIT.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- memRead  in  1  load request from EX/MEM
- memWrite  in  1  store request from EX/MEM
- word  in  1  1 = 32-bit access, 0 = byte access
- regWrite  in  1  instruction writes the register file
- rd  in  5  destination register
- result  in  32  ALU result / effective address
- readData2  in  32  store data
- flush  in  1  kill the instruction currently presented
- mem_req  out  1  memory request, held until acked
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address {result[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completion, 1-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ack
- stall  out  1  freezes IF/ID/EX and EX/MEM
- wb_regWrite  out  1  to MEM/WB
- wb_rd  out  5  to MEM/WB
- wb_data  out  32  load data or ALU result
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset:
  - state = IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_*, timeout_err and the counter all = 0.
  - stall = 0.
- States: IDLE, BUSY, DONE.
- access = (memRead | memWrite) & ~flush. If memRead and memWrite are both set, memWrite wins and the instruction is treated as a store.
- IDLE, no access:
  - Next edge: wb_regWrite = regWrite & ~flush, wb_rd = rd, wb_data = result. Latency 1 cycle; stall = 0.
- IDLE, access:
  - stall = 1 combinationally.
  - Next edge: mem_req = 1, mem_we = memWrite, address, byte enables and write data registered; wb_regWrite = 0; enter BUSY with counter = 0.
- BUSY:
  - stall = 1 and mem_req held with all mem_* outputs stable.
  - Counter increments each cycle without mem_ack.
- BUSY, mem_ack = 1:
  - Next edge: mem_req = 0, enter DONE.
  - Load: wb_data = formatted mem_rdata, wb_regWrite = regWrite.
  - Store: wb_regWrite = 0.
  - wb_rd = rd.
- BUSY, counter reaches MAX_WAIT with no ack:
  - Next edge: mem_req = 0, timeout_err = 1 (sticky until reset), wb_regWrite = 0, enter DONE.
- DONE:
  - stall = 0 for one cycle so EX/MEM advances at this edge; wb_* hold.
  - Next state is IDLE; the next instruction is evaluated there.
  - Memory cost: ack-wait cycles + 2 total.
- flush:
  - Sampled only in IDLE.
  - In BUSY it is ignored: a store still commits, and a load still completes with its writeback.
- Word access:
  - mem_be = 4'b1111, mem_wdata = readData2, wb_data = mem_rdata.
  - result[1:0] is ignored in the base build.
- Byte access:
  - lane = result[1:0], little-endian (lane 0 = bits 7:0).
  - mem_be = 4'b0001 << lane.
  - mem_wdata = readData2[7:0] replicated into all 4 lanes.
  - Load: wb_data = sign-extended rdata byte of that lane.
- mem_ack outside BUSY is ignored.
- reset asserted in BUSY: mem_req drops at that edge and any pending transaction is abandoned.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_err (1 bit, sticky, reset 0).
  - A word access with result[1:0] != 0 in IDLE issues no request, stays non-stalling, sets misalign_err, and writes back wb_regWrite = 0 after 1 cycle.
- Undefined:
  - No port; address low bits are silently dropped on word accesses.

Test Plan:
- Word load at addr 0x100; mem_ack 2 cycles after req with rdata 0xDEADBEEF -> stall high 4 cycles, wb_data = 0xDEADBEEF, wb_regWrite = 1, wb_rd = rd.
- Byte store 0xA5 at addr 0x203 -> mem_addr = 0x200, mem_be = 4'b1000, mem_wdata = 0xA5A5A5A5, wb_regWrite = 0.
- Byte load at addr 0x1 with rdata 0x00008000 -> wb_data = 0xFFFFFF80.
- Non-memory instruction, result 0x1234, regWrite = 1 -> stall never asserted, wb_data = 0x1234 one cycle later.
- MAX_WAIT = 4 with mem_ack never asserted -> mem_req drops after 4 BUSY cycles, timeout_err = 1, stall released through DONE.
- flush with memRead in IDLE -> no mem_req, wb_regWrite = 0; and flush asserted in BUSY -> transaction completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: consumes EX/MEM fields, runs a req/ack data-memory access, feeds MEM/WB.
// Latency: non-memory ops 1 cycle; memory ops hold stall for ack-wait + 2 cycles (IDLE, BUSY.., DONE).
// Backpressure: stall freezes upstream while an access is outstanding; MEM_ALIGN_CHECK_EN adds misalign_err.
module mem_access_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        word,
    input  logic        regWrite,
    input  logic [4:0]  rd,
    input  logic [31:0] result,
    input  logic [31:0] readData2,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_regWrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_err,
`endif
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         mem_req_q, mem_req_d;
    logic         mem_we_q, mem_we_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [3:0]   mem_be_q, mem_be_d;
    logic [31:0]  mem_wdata_q, mem_wdata_d;
    logic         op_word_q, op_word_d;
    logic [1:0]   op_lane_q, op_lane_d;
    logic         op_rw_q, op_rw_d;
    logic [4:0]   op_rd_q, op_rd_d;
    logic         wb_rw_q, wb_rw_d;
    logic [4:0]   wb_rd_q, wb_rd_d;
    logic [31:0]  wb_data_q, wb_data_d;
    logic         timeout_q, timeout_d;

    logic         access;
    logic         misalign;
    logic [1:0]   lane;
    logic [7:0]   rdata_byte;
    logic [31:0]  load_data;

    assign access = (memRead | memWrite) & ~flush;
    assign lane   = result[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign misalign     = word & (lane != 2'b00);
    assign misalign_err = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        unique case (op_lane_q)
            2'd0:    rdata_byte = mem_rdata[7:0];
            2'd1:    rdata_byte = mem_rdata[15:8];
            2'd2:    rdata_byte = mem_rdata[23:16];
            default: rdata_byte = mem_rdata[31:24];
        endcase
    end

    assign load_data = op_word_q ? mem_rdata : {{24{rdata_byte[7]}}, rdata_byte};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        op_word_d   = op_word_q;
        op_lane_d   = op_lane_q;
        op_rw_d     = op_rw_q;
        op_rd_d     = op_rd_q;
        wb_rw_d     = wb_rw_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        timeout_d   = timeout_q;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d  = misalign_q | (state_q == IDLE && access && misalign);
`endif
        stall       = 1'b0;

        unique case (state_q)
            IDLE: begin
                wb_rd_d   = rd;
                wb_data_d = result;
                if (access && !misalign) begin
                    stall       = 1'b1;
                    state_d     = BUSY;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = memWrite;
                    mem_addr_d  = {result[31:2], 2'b00};
                    mem_be_d    = word ? 4'b1111 : (4'b0001 << lane);
                    mem_wdata_d = word ? readData2 : {4{readData2[7:0]}};
                    op_word_d   = word;
                    op_lane_d   = lane;
                    op_rw_d     = regWrite;
                    op_rd_d     = rd;
                    wb_rw_d     = 1'b0;
                end else begin
                    // A misaligned word access retires here as a non-writing no-op.
                    mem_req_d = 1'b0;
                    wb_rw_d   = regWrite & ~flush & ~(access & misalign);
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    wb_rd_d   = op_rd_q;
                    if (mem_we_q) begin
                        wb_rw_d = 1'b0;
                    end else begin
                        wb_rw_d   = op_rw_q;
                        wb_data_d = load_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        mem_req_d = 1'b0;
                        timeout_d = 1'b1;
                        wb_rw_d   = 1'b0;
                        wb_rd_d   = op_rd_q;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            op_word_q   <= 1'b0;
            op_lane_q   <= '0;
            op_rw_q     <= 1'b0;
            op_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            timeout_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            op_word_q   <= op_word_d;
            op_lane_q   <= op_lane_d;
            op_rw_q     <= op_rw_d;
            op_rd_q     <= op_rd_d;
            wb_rw_q     <= wb_rw_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            timeout_q   <= timeout_d;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_regWrite = wb_rw_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl (MAX_WAIT = 4): scoreboard of expected writeback fields,
// with a bench-side memory that acks after a chosen number of request cycles.
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        memRead, memWrite, word, regWrite, flush;
    logic [4:0]  rd;
    logic [31:0] result, readData2;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall, wb_regWrite, timeout_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    int          sc, rc;
    logic [31:0] a_s, w_s;
    logic [3:0]  b_s;
    logic        we_s, unst, ok;

    mem_access_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .memRead(memRead), .memWrite(memWrite), .word(word), .regWrite(regWrite),
        .rd(rd), .result(result), .readData2(readData2), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic drive(input logic r, input logic w, input logic wd, input logic rw,
                         input logic [4:0] d, input logic [31:0] res, input logic [31:0] d2,
                         input logic fl);
        memRead = r; memWrite = w; word = wd; regWrite = rw;
        rd = d; result = res; readData2 = d2; flush = fl;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    endtask

    // Called right after drive(); returns at the DONE-cycle negedge (stall released).
    task automatic run_access(input int ack_after, input logic [31:0] rdata, input logic flush_busy,
                              output int stall_cyc, output int req_cyc,
                              output logic [31:0] addr_s, output logic [3:0] be_s,
                              output logic [31:0] wd_s, output logic wes, output logic unstable,
                              output logic done_ok);
        stall_cyc = 0; req_cyc = 0; addr_s = '0; be_s = '0; wd_s = '0; wes = 1'b0;
        unstable = 1'b0; done_ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
            if (!stall) begin
                done_ok = 1'b1;
                break;
            end
            stall_cyc++;
            if (mem_req) begin
                if (req_cyc == 0) begin
                    addr_s = mem_addr; be_s = mem_be; wd_s = mem_wdata; wes = mem_we;
                end else if (mem_addr !== addr_s || mem_be !== be_s || mem_wdata !== wd_s || mem_we !== wes) begin
                    unstable = 1'b1;
                end
                if (flush_busy) flush = 1'b1;
                if (ack_after >= 0 && req_cyc == ack_after) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
                req_cyc++;
            end
        end
        nop();
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; nop();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if ({mem_req, mem_we, mem_be, stall} !== 7'd0) begin errors++; $display("FAIL reset_ctl: got %b want 0", {mem_req, mem_we, mem_be, stall}); end
        checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem: got %h %h want 0", mem_addr, mem_wdata); end
        checks++; if ({wb_regWrite, wb_rd, wb_data} !== 38'd0) begin errors++; $display("FAIL reset_wb: got %b %h %h want 0", wb_regWrite, wb_rd, wb_data); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
        reset = 1'b0;
    endtask

    task automatic pop_compare(input string name);
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL %s_sb: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            checks++; if (wb_regWrite !== e.rw) begin errors++; $display("FAIL %s_rw: got %b want %b", name, wb_regWrite, e.rw); end
            checks++; if (wb_rd !== e.rd) begin errors++; $display("FAIL %s_rd: got %0d want %0d", name, wb_rd, e.rd); end
            if (e.chk_data) begin
                checks++; if (wb_data !== e.data) begin errors++; $display("FAIL %s_data: got %h want %h", name, wb_data, e.data); end
            end
        end
    endtask

    task automatic test_word_load();
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h100, 32'h0, 1'b0);
        exp_q.push_back('{1'b1, 5'd5, 32'hDEADBEEF, 1'b1});
        run_access(2, 32'hDEADBEEF, 1'b0, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        checks++; if (!ok || sc != 4) begin errors++; $display("FAIL wl_stall: got %0d cycles (done %b) want 4", sc, ok); end
        checks++; if (rc != 3) begin errors++; $display("FAIL wl_req: got %0d want 3", rc); end
        checks++; if ({a_s, b_s, we_s, unst} !== {32'h100, 4'b1111, 1'b0, 1'b0}) begin errors++; $display("FAIL wl_bus: got %h %b we=%b unst=%b want 100 1111 0 0", a_s, b_s, we_s, unst); end
        pop_compare("wl");
    endtask

    task automatic test_byte_store();
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h203, 32'h123456A5, 1'b0);
        exp_q.push_back('{1'b0, 5'd9, 32'h0, 1'b0});
        run_access(0, 32'h0, 1'b0, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        checks++; if (!ok || sc != 2) begin errors++; $display("FAIL sb_stall: got %0d want 2", sc); end
        checks++; if ({a_s, b_s, w_s, we_s} !== {32'h200, 4'b1000, 32'hA5A5A5A5, 1'b1}) begin errors++; $display("FAIL sb_bus: got %h %b %h %b want 200 1000 a5a5a5a5 1", a_s, b_s, w_s, we_s); end
        pop_compare("sb");
    endtask

    task automatic test_byte_load();
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1, 32'h0, 1'b0);
        exp_q.push_back('{1'b1, 5'd3, 32'hFFFFFF80, 1'b1});
        run_access(1, 32'h00008000, 1'b0, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        checks++; if (!ok || sc != 3 || {a_s, b_s} !== {32'h0, 4'b0010}) begin errors++; $display("FAIL lb1_bus: got sc=%0d %h %b want 3 0 0010", sc, a_s, b_s); end
        pop_compare("lb1");
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h7, 32'h0, 1'b0);
        exp_q.push_back('{1'b1, 5'd11, 32'h0000007F, 1'b1});
        run_access(0, 32'h7F0000FF, 1'b0, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        checks++; if (!ok || {a_s, b_s} !== {32'h4, 4'b1000}) begin errors++; $display("FAIL lb3_bus: got %h %b want 4 1000", a_s, b_s); end
        pop_compare("lb3");
    endtask

    task automatic test_nonmem();
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1234, 32'h0, 1'b0);
        mem_ack = 1'b1;
        exp_q.push_back('{1'b1, 5'd7, 32'h1234, 1'b1});
        @(negedge clock);
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL nm_stall: got stall=%b req=%b want 0 0", stall, mem_req); end
        @(posedge clock); #1;
        nop(); mem_ack = 1'b0;
        @(negedge clock);
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL nm_ack_ignored: got stall=%b req=%b want 0 0", stall, mem_req); end
        pop_compare("nm");
    endtask

    task automatic test_flush_idle();
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h40, 32'h0, 1'b1);
        exp_q.push_back('{1'b0, 5'd4, 32'h40, 1'b1});
        @(negedge clock);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fi_stall: got %b want 0", stall); end
        @(posedge clock); #1;
        nop();
        @(negedge clock);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fi_req: got %b want 0", mem_req); end
        pop_compare("fi");
    endtask

    task automatic test_flush_busy();
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h80, 32'h0, 1'b0);
        exp_q.push_back('{1'b1, 5'd6, 32'hCAFEF00D, 1'b1});
        run_access(1, 32'hCAFEF00D, 1'b1, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        checks++; if (!ok || sc != 3 || rc != 2) begin errors++; $display("FAIL fb_cycles: got sc=%0d rc=%0d want 3 2", sc, rc); end
        pop_compare("fb");
    endtask

    task automatic test_both_word_store();
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 32'h12, 32'h11223344, 1'b0);
        exp_q.push_back('{1'b0, 5'd2, 32'h0, 1'b0});
        run_access(0, 32'h55555555, 1'b0, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        checks++; if ({a_s, b_s, w_s, we_s} !== {32'h10, 4'b1111, 32'h11223344, 1'b1}) begin errors++; $display("FAIL sw_bus: got %h %b %h %b want 10 1111 11223344 1", a_s, b_s, w_s, we_s); end
        pop_compare("sw");
    endtask

    task automatic test_ack_last();
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h300, 32'h0, 1'b0);
        exp_q.push_back('{1'b1, 5'd12, 32'h0BADF00D, 1'b1});
        run_access(3, 32'h0BADF00D, 1'b0, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        checks++; if (!ok || sc != 5 || rc != 4) begin errors++; $display("FAIL al_cycles: got sc=%0d rc=%0d want 5 4", sc, rc); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL al_timeout: got %b want 0", timeout_err); end
        pop_compare("al");
    endtask

    task automatic test_timeout();
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h400, 32'h0, 1'b0);
        exp_q.push_back('{1'b0, 5'd8, 32'h0, 1'b0});
        run_access(-1, 32'h0, 1'b0, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        checks++; if (!ok || sc != 5 || rc != 4) begin errors++; $display("FAIL to_cycles: got sc=%0d rc=%0d done=%b want 5 4 1", sc, rc, ok); end
        checks++; if (timeout_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL to_flag: got err=%b req=%b want 1 0", timeout_err, mem_req); end
        pop_compare("to");
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_busy();
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h500, 32'h0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rb_req: got %b want 1", mem_req); end
        reset = 1'b1; nop();
        @(negedge clock);
        checks++; if ({mem_req, stall, timeout_err, wb_regWrite} !== 4'b0000) begin errors++; $display("FAIL rb_clear: got %b want 0000", {mem_req, stall, timeout_err, wb_regWrite}); end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h600, 32'h0, 1'b0);
        exp_q.push_back('{1'b1, 5'd13, 32'h01020304, 1'b1});
        run_access(0, 32'h01020304, 1'b0, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        pop_compare("bb1");
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 32'h602, 32'h0, 1'b0);
        exp_q.push_back('{1'b1, 5'd14, 32'hFFFFFFAB, 1'b1});
        run_access(1, 32'h00AB0000, 1'b0, sc, rc, a_s, b_s, w_s, we_s, unst, ok);
        checks++; if (!ok || sc != 3 || b_s !== 4'b0100) begin errors++; $display("FAIL bb2_bus: got sc=%0d be=%b want 3 0100", sc, b_s); end
        pop_compare("bb2");
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_nonmem();
        test_flush_idle();
        test_flush_busy();
        test_both_word_store();
        test_ack_last();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
